// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// 32 iteration cycles plus one sign-fix cycle, with MTHI/MTLO writes accepted while idle.
module mult_div_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        is_div_q, is_div_d;
   logic        neg_q, neg_d;
   logic        rneg_q, rneg_d;
   logic [31:0] opnd_q, opnd_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        done_q, done_d;

   // Operand magnitudes; 0x80000000 negates to itself, which reads correctly as unsigned.
   logic        op_signed;
   logic [31:0] mag_a, mag_b;

   assign op_signed = ~op[0];
   assign mag_a     = (op_signed && src_a[31]) ? (~src_a + 32'd1) : src_a;
   assign mag_b     = (op_signed && src_b[31]) ? (~src_b + 32'd1) : src_b;

   // Multiply step: acc = {partial product, remaining multiplier bits}.
   logic [32:0] mul_sum;
   logic [63:0] mul_next;

   assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
   assign mul_next = {mul_sum, acc_q[31:1]};

   // Divide step: acc = {partial remainder, dividend bits shifting into quotient bits}.
   logic [32:0] rem_sh;
   logic [32:0] rem_diff;
   logic        q_bit;
   logic [63:0] div_next;

   assign rem_sh   = acc_q[63:31];
   assign rem_diff = rem_sh - {1'b0, opnd_q};
   assign q_bit    = (rem_sh >= {1'b0, opnd_q});
   assign div_next = {(q_bit ? rem_diff[31:0] : rem_sh[31:0]), acc_q[30:0], q_bit};

   // Sign-corrected results, consumed only in the fix cycle.
   logic [63:0] prod_fix;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   assign prod_fix = neg_q  ? (~acc_q + 64'd1)         : acc_q;
   assign quo_fix  = neg_q  ? (~acc_q[31:0] + 32'd1)   : acc_q[31:0];
   assign rem_fix  = rneg_q ? (~acc_q[63:32] + 32'd1)  : acc_q[63:32];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (hi_we) hi_d = wdata;
            if (lo_we) lo_d = wdata;
            if (start) begin
               is_div_d = op[1];
               neg_d    = op_signed & (src_a[31] ^ src_b[31]);
               rneg_d   = op_signed & src_a[31];
               cnt_d    = 5'd0;
               if (op[1]) begin
                  opnd_d = mag_b;
                  acc_d  = {32'd0, mag_a};
               end else begin
                  opnd_d = mag_a;
                  acc_d  = {32'd0, mag_b};
               end
               state_d = StCalc;
            end
         end
         StCalc: begin
            acc_d = is_div_q ? div_next : mul_next;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = StFix;
         end
         StFix: begin
            if (is_div_q) begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end else begin
               hi_d = prod_fix[63:32];
               lo_d = prod_fix[31:0];
            end
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         cnt_q    <= 5'd0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         opnd_q   <= 32'd0;
         acc_q    <= 64'd0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
      end
   end

   assign busy = (state_q != StIdle);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: a reference model pushes expected HI/LO into a
// scoreboard queue at start; results are popped and checked when done pulses.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] src_a, src_b, wdata;
   logic        hi_we, lo_we;
   logic        busy, done;
   logic [31:0] hi, lo;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t sb_q[$];

   localparam logic [1:0] OpMult = 2'b00, OpMultu = 2'b01, OpDiv = 2'b10, OpDivu = 2'b11;

   mult_div_unit dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .src_a (src_a),
      .src_b (src_b),
      .hi_we (hi_we),
      .lo_we (lo_we),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      exp_t            r;
      longint          sa, sb, sp, sq, sr;
      longint unsigned up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         OpMult: begin
            sp   = sa * sb;
            r.hi = sp[63:32];
            r.lo = sp[31:0];
         end
         OpMultu: begin
            up   = {32'd0, a} * {32'd0, b};
            r.hi = up[63:32];
            r.lo = up[31:0];
         end
         OpDivu: begin
            if (b == 32'd0) begin
               r.lo = 32'hFFFF_FFFF;
               r.hi = a;
            end else begin
               r.lo = a / b;
               r.hi = a % b;
            end
         end
         default: begin
            if (b == 32'd0) begin
               // Raw quotient all-ones, negated when the dividend is negative.
               r.lo = a[31] ? 32'd1 : 32'hFFFF_FFFF;
               r.hi = a;
            end else begin
               sq   = sa / sb;
               sr   = sa % sb;
               r.lo = sq[31:0];
               r.hi = sr[31:0];
            end
         end
      endcase
      return r;
   endfunction

   task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                           input bit push);
      @(negedge clk);
      op    = o;
      src_a = a;
      src_b = b;
      start = 1'b1;
      if (push) sb_q.push_back(model(o, a, b));
      @(posedge clk);
      #1;
      start = 1'b0;
      src_a = ~a;
      src_b = ~b;
   endtask

   task automatic wait_check(input string tag, input bit chk_lat);
      int   cyc;
      bit   seen;
      exp_t e;
      cyc  = 0;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         else if (busy) cyc++;
      end
      chk({tag, "_done_seen"}, 64'(seen), 64'd1);
      if (chk_lat) chk({tag, "_busy_cycles"}, 64'(cyc), 64'd33);
      chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk({tag, "_hi_lo"}, {hi, lo}, {e.hi, e.lo});
      end else begin
         chk({tag, "_scoreboard_empty"}, 64'd1, 64'd0);
      end
      @(negedge clk);
      chk({tag, "_done_width"}, 64'(done), 64'd0);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      op    = 2'b00;
      src_a = 32'd0;
      src_b = 32'd0;
      hi_we = 1'b0;
      lo_we = 1'b0;
      wdata = 32'd0;
      repeat (3) @(negedge clk);
      chk("reset_state", {busy, done, hi, lo}, {2'b00, 64'd0});
      reset = 1'b0;

      start_op(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      wait_check("multu_max", 1'b1);
      chk("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

      start_op(OpMult, 32'hFFFF_FFFD, 32'd5, 1'b1);
      wait_check("mult_neg3x5", 1'b1);
      start_op(OpMult, 32'h8000_0000, 32'h8000_0000, 1'b1);
      wait_check("mult_min_sq", 1'b1);
      start_op(OpDivu, 32'd100, 32'd7, 1'b1);
      wait_check("divu_100_7", 1'b1);
      start_op(OpDiv, 32'hFFFF_FFF9, 32'd2, 1'b1);
      wait_check("div_neg7_2", 1'b1);
      chk("div_neg7_2_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      start_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      wait_check("div_min_neg1", 1'b1);
      start_op(OpDivu, 32'd5, 32'd0, 1'b1);
      wait_check("divu_by_zero", 1'b1);
      start_op(OpDiv, 32'hFFFF_FFF0, 32'd0, 1'b1);
      wait_check("div_neg_by_zero", 1'b1);

      for (int k = 0; k < 4; k++) begin
         start_op(2'(k), $urandom, $urandom, 1'b1);
         wait_check("random_op", 1'b1);
      end

      // Start and MTHI during busy must both be dropped.
      start_op(OpMultu, 32'd6, 32'd7, 1'b1);
      repeat (3) @(negedge clk);
      start = 1'b1;
      op    = OpDivu;
      src_a = 32'd1;
      src_b = 32'd1;
      hi_we = 1'b1;
      wdata = 32'h1234;
      @(negedge clk);
      start = 1'b0;
      hi_we = 1'b0;
      wait_check("busy_ignore", 1'b0);
      chk("busy_ignore_no_queue", 64'(busy), 64'd0);

      @(negedge clk);
      lo_we = 1'b1;
      wdata = 32'hABCD;
      @(posedge clk);
      #1;
      lo_we = 1'b0;
      chk("mtlo_idle", {hi, lo}, {32'd0, 32'h0000_ABCD});

      start_op(OpMultu, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
      repeat (10) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("abort_state", {busy, done, hi, lo}, {2'b00, 64'd0});
      @(negedge clk);
      reset = 1'b0;
      begin
         bit saw_done = 1'b0;
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
         end
         chk("abort_no_done", 64'(saw_done), 64'd0);
      end
      start_op(OpDivu, 32'd9, 32'd3, 1'b1);
      wait_check("divu_after_abort", 1'b1);
      chk("divu_9_3_const", {hi, lo}, {32'd0, 32'd3});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative HI/LO multiply/divide unit in the EX stage of the MIPS pipeline. It consumes the two register-file read operands for MULT/MULTU/DIV/DIVU and computes the 64-bit result over multiple cycles. The result goes into the architectural HI/LO registers, which are read by MFHI/MFLO. While it works it raises busy so the hazard logic can stall later HI/LO accesses.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high
- start  input  1  begin operation; sampled only in IDLE
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  input  32  rs operand (multiplicand / dividend)
- src_b  input  32  rt operand (multiplier / divisor)
- hi_we  input  1  MTHI write strobe
- lo_we  input  1  MTLO write strobe
- wdata  input  32  MTHI/MTLO data
- busy  output  1  high whenever state is not IDLE (combinational from state)
- done  output  1  one-cycle pulse, registered, after HI/LO update
- hi  output  32  HI register
- lo  output  32  LO register

## Operation
- States: IDLE, CALC, FIX.
- **IDLE, start=1:**
  - Latch op and the operand magnitudes. Signed ops use two's-complement absolute value; 0x80000000 is kept as unsigned 0x80000000.
  - Record the result signs:
    - product sign = a[31]^b[31]
    - quotient sign = a[31]^b[31]
    - remainder sign = a[31]
    - Unsigned ops record both signs as 0.
  - Clear the 5-bit iteration counter and go to CALC.
- **CALC:** one radix-2 step per cycle; the counter increments each cycle. After the step with counter==31, go to FIX.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract. Quotient bit = 1 when remainder ≥ divisor.
- **FIX:**
  - Apply sign correction: negate the 64-bit product, negate the quotient, negate the remainder, each per its recorded sign.
  - Write HI/LO:
    - Multiply: HI=product[63:32], LO=product[31:0].
    - Divide: LO=quotient, HI=remainder.
  - Set done, go to IDLE.
- **Divide by zero:** runs the full sequence with no special path. Raw result is LO=0xFFFFFFFF, HI=|dividend|. Sign correction then applies normally, so for DIV (signed) the final values depend on the dividend sign.
- **DIV 0x80000000 / -1:** LO=0x80000000, HI=0. Falls out of the magnitude arithmetic.
- **start while busy:** ignored, with no queuing.
- **hi_we/lo_we:**
  - In IDLE: write wdata to HI/LO at the clock edge.
  - While busy: ignored.
  - In IDLE with start in the same cycle: the write takes effect, then the result later overwrites both registers.
- Operands are captured at start. Later changes on src_a/src_b have no effect.

## Timing
- Reset (async): state=IDLE, counter=0, hi=0, lo=0, done=0, busy=0.
- Start sampled at edge E0.
  - busy=1 from after E0 until after E33: 32 CALC cycles plus 1 FIX cycle, 33 cycles total.
  - hi/lo update at E33.
  - done=1 for the cycle between E33 and E34; busy=0 in that same cycle.
- A new start may be sampled at E33's following edge (E34) at the earliest, i.e. the cycle in which done=1. Back-to-back throughput is one operation per 34 cycles.
- Reset mid-operation: aborts immediately. HI/LO are cleared to 0, no done pulse. The next start behaves as from power-up.
- hi/lo are register outputs only, with no same-cycle bypass. The consumer reads the new values from the cycle after E33.

## Test plan
- After reset, MULTU 0xFFFFFFFF × 0xFFFFFFFF → busy high 33 cycles, then HI=0xFFFFFFFE, LO=0x00000001, done pulse exactly 1 cycle.
- MULT -3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1; MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- DIVU 100/7 → LO=0x0000000E, HI=0x00000002; DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/-1 → LO=0x80000000, HI=0.
- DIVU 5/0 → LO=0xFFFFFFFF, HI=0x00000005 after the full 33-cycle busy.
- Start second op and pulse hi_we with wdata=0x1234 while busy → both ignored, first result intact. Then in IDLE, lo_we with wdata=0xABCD → LO=0xABCD next cycle.
- Assert reset at cycle 10 of a MULTU → busy=0, HI=LO=0, no done pulse. Then re-run DIVU 9/3 → LO=3, HI=0.
